// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

    // Requester count is tied to the 3-bit mux select.
    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_t;

    // One-hot vector with bit s set.
    function automatic req_t onehot(input sel_t s);
        req_t v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Next index with natural 7->0 wrap from the 3-bit width.
    function automatic sel_t wrap_inc(input sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set request at or after ptr_i,
// wrapping 7->0. idx_o is only meaningful when found_o is high.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  sel_t               ptr_i,
    output logic               found_o,
    output sel_t               idx_o
);

    sel_t w_cand;

    // Walk the requests from the priority pointer and keep the first hit.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        w_cand  = ptr_i;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = ptr_i + sel_t'(i);
            if (!found_o && req_i[w_cand]) begin
                found_o = 1'b1;
                idx_o   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 datapath mux. A grant is held until the
// owner's last beat, a beat-limit timeout or an abandon; priority then rotates
// to the index after the owner and a new owner is picked in the same cycle.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    input  logic               ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               valid_o,
    output logic               busy_o
);

    if (NUM_REQ != 8) begin : g_bad_num_req
        $error("mux8_rr_arbiter supports exactly 8 requesters");
    end
    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("mux8_rr_arbiter needs MAX_BEATS >= 1");
    end

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t BEAT_LAST = cnt_t'(MAX_BEATS - 1);

    arb_state_e r_state, w_state_nxt;
    sel_t       r_ptr, w_ptr_nxt;
    sel_t       r_owner, w_owner_nxt;
    cnt_t       r_beat_cnt, w_beat_cnt_nxt;

    logic w_busy;
    logic w_owner_req;
    logic w_valid;
    logic w_xfer;
    logic w_at_limit;
    logic w_release;
    sel_t w_rel_ptr;
    sel_t w_pick_ptr;
    logic w_found;
    sel_t w_pick_idx;

    // Handshake and release decode for the current owner.
    always_comb begin
        w_busy      = (r_state == GRANT);
        w_owner_req = req_i[r_owner];
        w_valid     = w_busy & w_owner_req;
        w_xfer      = w_valid & ready_i;
        w_at_limit  = (r_beat_cnt == BEAT_LAST);
        // An abandon can never coincide with a transfer since valid needs the request.
        w_release   = w_busy & ((w_xfer & (last_i[r_owner] | w_at_limit)) | ~w_owner_req);
        w_rel_ptr   = wrap_inc(r_owner);
        // One picker serves both the idle pick and the release re-pick.
        w_pick_ptr  = w_busy ? w_rel_ptr : r_ptr;
    end

    rr_pick8 u_pick (
        .req_i  (req_i),
        .ptr_i  (w_pick_ptr),
        .found_o(w_found),
        .idx_o  (w_pick_idx)
    );

    // Next-state logic: arbitration in IDLE, beat tracking and handover in GRANT.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt    = GRANT;
                    w_owner_nxt    = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt      = w_rel_ptr;
                    w_beat_cnt_nxt = '0;
                    if (w_found) begin
                        w_owner_nxt = w_pick_idx;
                    end else begin
                        // Owner is kept so the mux select holds while idle.
                        w_state_nxt = IDLE;
                    end
                end else if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + cnt_t'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State registers; reset drops any grant immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Outputs decode from registered state only, except valid which follows the request.
    always_comb begin
        busy_o  = w_busy;
        valid_o = w_valid;
        sel_o   = r_owner;
        gnt_o   = w_busy ? onehot(r_owner) : '0;
    end

    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_valid_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o |-> busy_o);
    a_sel_matches : assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o |-> (gnt_o == onehot(sel_o)));
    a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_beat_cnt <= BEAT_LAST);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed, table-driven bench for mux8_rr_arbiter. Each row is one clock
// cycle: inputs are driven on the falling edge and the outputs checked 1 ns later.
module tb_mux8_rr_arbiter;

    logic       clk_i;
    logic       rst_ni;
    logic [7:0] req_i;
    logic [7:0] last_i;
    logic       ready_i;
    logic [7:0] gnt_o;
    logic [2:0] sel_o;
    logic       valid_o;
    logic       busy_o;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [7:0] req;
        logic [7:0] last;
        logic       rdy;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    mux8_rr_arbiter #(.MAX_BEATS(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_i),
        .last_i (last_i),
        .ready_i(ready_i),
        .gnt_o  (gnt_o),
        .sel_o  (sel_o),
        .valid_o(valid_o),
        .busy_o (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic add(input logic [7:0] req, input logic [7:0] last, input logic rdy,
                       input logic [7:0] gnt, input logic [2:0] sel, input logic valid,
                       input logic busy, input int n);
        vec_t v;
        v.req   = req;
        v.last  = last;
        v.rdy   = rdy;
        v.gnt   = gnt;
        v.sel   = sel;
        v.valid = valid;
        v.busy  = busy;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] gnt, input logic [2:0] sel,
                         input logic valid, input logic busy);
        n_checks++;
        if (gnt_o !== gnt || sel_o !== sel || valid_o !== valid || busy_o !== busy) begin
            n_errors++;
            $display("FAIL %s: got gnt=%h sel=%0d valid=%b busy=%b, want gnt=%h sel=%0d valid=%b busy=%b",
                     name, gnt_o, sel_o, valid_o, busy_o, gnt, sel, valid, busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Idle after reset.
        add(8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 10);
        // Single requester 4, three beats; it is re-granted on the last beat
        // because its request is still high, then abandons.
        add(8'h10, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1);
        add(8'h10, 8'h00, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 2);
        add(8'h10, 8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 1'b1, 1);
        add(8'h00, 8'h00, 1'b1, 8'h10, 3'd4, 1'b0, 1'b1, 1);
        // ptr is now 5: 0x11 must pick 0, not 4. Select held at 4 while idle.
        add(8'h11, 8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 1);
        add(8'h00, 8'h00, 1'b1, 8'h01, 3'd0, 1'b0, 1'b1, 1);
        // Round robin 0x81 with one beat per grant, ptr=1 so 7 goes first.
        add(8'h81, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1);
        add(8'h81, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1);
        add(8'h81, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1);
        add(8'h81, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1);
        add(8'h81, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1);
        add(8'h00, 8'h00, 1'b1, 8'h80, 3'd7, 1'b0, 1'b1, 1);
        add(8'h00, 8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0, 1);
        // Wrap: owner 6 releases, ptr=7, 0x41 picks 0. Non-owner last ignored, stall holds.
        add(8'h40, 8'h00, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 1);
        add(8'h41, 8'h40, 1'b1, 8'h40, 3'd6, 1'b1, 1'b1, 1);
        add(8'h41, 8'h40, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1);
        add(8'h41, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1, 1);
        add(8'h41, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1);
        add(8'h00, 8'h00, 1'b0, 8'h40, 3'd6, 1'b0, 1'b1, 1);
        add(8'h00, 8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0, 1);
        // Beat limit: 16 beats of owner 2 alone (silent re-grant), then 16 more
        // with requester 5 waiting; the 16th transfer of the second grant hands over.
        add(8'h04, 8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0, 1);
        add(8'h04, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 16);
        add(8'h24, 8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 16);
        add(8'h20, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 1'b1, 1);
        add(8'h00, 8'h00, 1'b0, 8'h20, 3'd5, 1'b0, 1'b1, 1);
        // Abandon: owner 3 (picked from ptr=6 via wrap) drops its request with ready low.
        add(8'h08, 8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, 1);
        add(8'h08, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 1'b1, 2);
        add(8'h00, 8'h08, 1'b1, 8'h08, 3'd3, 1'b0, 1'b1, 1);
        add(8'h00, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1);
        // ptr=4 after the abandon: 0x48 picks 6.
        add(8'h48, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1);
        add(8'h48, 8'h00, 1'b0, 8'h40, 3'd6, 1'b1, 1'b1, 1);

        // Reset state, with requests pending to show valid stays low.
        rst_ni  = 1'b0;
        req_i   = 8'hff;
        last_i  = 8'hff;
        ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        req_i   = 8'h00;
        last_i  = 8'h00;
        ready_i = 1'b0;
        rst_ni  = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            req_i   = vecs[i].req;
            last_i  = vecs[i].last;
            ready_i = vecs[i].rdy;
            #1;
            check($sformatf("row%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid,
                  vecs[i].busy);
        end

        // Asynchronous reset between edges while owner 6 holds the grant.
        @(posedge clk_i);
        #1;
        check("grant_before_reset", 8'h40, 3'd6, 1'b1, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("reset_released_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        // ptr restarted at 0, so 0x48 now picks 3.
        @(negedge clk_i);
        #1;
        check("post_reset_pick", 8'h08, 3'd3, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 datapath mux between 8 requesters.
- Drives the mux select and one-hot grant, and tracks per-grant beats with a valid/ready handshake toward the downstream consumer.
- Holds the grant until the owner's last beat, a beat-limit timeout, or an abandon, then rotates priority.
- Sits between requesting units (e.g. memory/CSR/writeback sources) and the shared mux plus its consumer.

Parameters:
- NUM_REQ, 8: number of requesters; fixed at 8 to match the 3-bit mux select; any other value is an elaboration error.
- SEL_W, 3: select width, equal to $clog2(NUM_REQ).
- MAX_BEATS, 16: maximum beats per grant before forced release; must be ≥1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_i  input  8  per-requester request; held high while that requester has beats to send.
- last_i  input  8  per-requester last-beat flag; only the owner's bit is sampled, and only on a transfer.
- ready_i  input  1  downstream accepts the current mux output beat.
- gnt_o  output  8  one-hot grant; all-zero when idle.
- sel_o  output  3  mux select, equal to the owner index; holds its last value when idle.
- valid_o  output  1  beat present on the mux output; equals busy_o & req_i[owner].
- busy_o  output  1  a grant is active (state GRANT).

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - state=IDLE, ptr=0, owner=0, beat_cnt=0.
  - gnt_o=0, sel_o=0, valid_o=0, busy_o=0.
- Pick function:
  - Scans req_i starting at ptr and wrapping 7→0.
  - Returns the first set index plus a found flag.
  - ptr is the highest-priority index.
- IDLE:
  - If any req_i bit is set: owner←pick, gnt_o←onehot(pick), sel_o←pick, beat_cnt←0, go to GRANT.
  - Arbitration latency is 1 cycle: the request is sampled in cycle N and the grant is visible in cycle N+1.
  - Otherwise stay in IDLE.
- GRANT:
  - Transfer condition: valid_o & ready_i.
  - On a transfer, beat_cnt increments.
  - Release fires on any of:
    - (a) transfer & last_i[owner];
    - (b) transfer & beat_cnt==MAX_BEATS-1;
    - (c) req_i[owner]==0 (abandon; no transfer that cycle).
  - On release:
    - ptr←(owner+1) mod 8, with wrap 7→0.
    - Re-pick in the same cycle using the new ptr and the current req_i; the owner's own bit is included at lowest priority.
    - If found: stay in GRANT with the new owner, gnt_o and sel_o updated next cycle, beat_cnt←0. No idle bubble occurs.
    - If not found: go to IDLE, gnt_o←0, sel_o holds.
  - Without release: owner, gnt_o and sel_o are stable. ready_i=0 simply stalls and beat_cnt holds.
- Width rules:
  - beat_cnt width is $clog2(MAX_BEATS+1).
  - ptr, owner and sel_o are 3 bits; all wrap arithmetic is mod 8.
- Invariants:
  - gnt_o is one-hot or zero.
  - gnt_o changes only on a clock edge.
  - sel_o == index of the gnt_o bit whenever busy_o=1.
  - valid_o never asserts while busy_o=0.
- Non-owner req_i/last_i changes have no effect during GRANT.
- Reset mid-grant: the grant drops immediately (asynchronously) and no partial state survives.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ and SEL_W localparams;
  - typedef enum logic {IDLE, GRANT} arb_state_e;
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module rr_pick8: purely combinational rotating priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: found, idx[2:0].
  - Used for both the IDLE pick and the release re-pick.
  - Unit-testable exhaustively (2^11 cases).

Test Plan:
- Reset then req_i=8'h00 for 10 cycles -> gnt_o=0, sel_o=0, busy_o=0, valid_o=0 throughout.
- Single requester: req_i=8'h10, ready_i=1, last_i[4] high on the 3rd beat -> gnt_o=8'h10 and sel_o=4 from the next cycle, 3 transfers, then IDLE and ptr=5.
- Round-robin: req_i=8'h81 constant, every grant 1 beat with last -> owners 0,7,0,7… back-to-back with no idle cycle between grants.
- Wrap: ptr=7 after owner 6 releases, req_i=8'h41 -> next owner is 0 (scan 7→0), not 6.
- Beat limit: MAX_BEATS=16, req_i[2] held, last_i=0, ready_i=1 -> release after exactly the 16th transfer; with req_i=8'h04 only, owner 2 is re-granted immediately.
- Abandon and async reset: owner 3 drops req_i[3] with ready_i=0 -> release next edge without a transfer. In a separate run, assert rst_ni low mid-grant between edges -> gnt_o=0, sel_o=0 immediately.
